store_packer: RTL and testbench
===============================

Name: store_packer

Overview:
- Store-side data formatter between the MEM stage and data RAM.
- Accepts store requests (sb/sh/sw) carrying a byte address and register data.
- Replicates the data onto the proper byte lanes, generates byte enables and flags misaligned stores as address errors.
- Buffers accepted stores in a small FIFO so RAM back-pressure does not drop requests.

Parameters:
- DEPTH, 2, number of store-buffer entries (power of two, ≥2).
- AW, 32, byte-address width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  store request present.
- in_ready  output  1  buffer can accept; equals (count < DEPTH).
- in_addr  input  AW  byte address of the store.
- in_data  input  32  register rt value; only low byte/half used for sb/sh.
- in_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- out_valid  output  1  head entry valid toward RAM.
- out_ready  input  1  RAM accepts head entry this cycle.
- out_addr  output  AW  word-aligned address, low 2 bits forced to 0.
- out_wdata  output  32  lane-replicated write data.
- out_be  output  4  byte enables, bit i enables bits [8i+7:8i].
- ades  output  1  one-cycle pulse on a rejected misaligned or illegal store.
- bad_vaddr  output  AW  address of the most recent rejected store.

Behaviour:
- Reset (rst = 1 at clock edge):
  - count = 0, read and write pointers = 0.
  - out_valid = 0, ades = 0, bad_vaddr = 0.
  - out_addr, out_wdata, out_be present 0 while empty.
  - Reset mid-operation discards all buffered entries.
- Handshake:
  - Push occurs when in_valid & in_ready; pop occurs when out_valid & out_ready.
  - in_ready depends only on count, never on in_valid or out_ready; there is no same-cycle bypass when full.
- Packing is little-endian and applied before enqueue:
  - byte: wdata = {4{in_data[7:0]}}, be = 4'b0001 << in_addr[1:0].
  - half: wdata = {2{in_data[15:0]}}, be = in_addr[1] ? 4'b1100 : 4'b0011.
  - word: wdata = in_data, be = 4'b1111.
- Alignment check:
  - Error if half with in_addr[0] = 1, word with in_addr[1:0] ≠ 00, or in_size = 11.
  - An erroring request that handshakes (in_valid & in_ready) is consumed but not enqueued.
  - On the next cycle: ades = 1 for exactly one cycle and bad_vaddr = in_addr; bad_vaddr then holds until the next error.
  - Errors never change count.
- Latency:
  - An entry pushed at edge N is visible at the outputs from N+1 (out_valid = 1 after the edge) when the FIFO was empty.
  - Otherwise the entry appears behind older entries in strict FIFO order.
- Output stability: while out_valid & !out_ready, out_addr, out_wdata and out_be are held stable.
- Count rules:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged, entry order preserved.
  - Pointers wrap modulo DEPTH.
- Boundary cases:
  - full: in_ready = 0; a pop at full makes in_ready = 1 on the next cycle.
  - empty: out_valid = 0; out_ready is ignored.
  - Erroring request while full: in_ready = 0, so it is not taken and no ades pulse occurs until accepted.
  - Back-to-back errors produce consecutive ades pulses; bad_vaddr tracks the latest.

Test Plan:
- Byte lanes: reset, then sb addr = 0x1003, data = 0xA5, out_ready = 1 → next cycle out_valid = 1, out_addr = 0x1000, out_wdata = 0xA5A5A5A5, out_be = 4'b1000; one cycle later out_valid = 0.
- Half and word: sh addr = 0x2002, data = 0x1234BEEF, then sw addr = 0x2004, data = 0xCAFEF00D → entries in order: (0x2000, 0xBEEFBEEF, 1100), then (0x2004, 0xCAFEF00D, 1111).
- Misaligned: sh addr = 0x3001, then sw addr = 0x3006 → two consecutive ades pulses; bad_vaddr = 0x3001, then 0x3006; out_valid stays 0; count stays 0.
- Back-pressure/full (DEPTH = 2): out_ready = 0, push three sw requests (0x10, 0x14, 0x18) → in_ready = 0 after the second push, third request held; raise out_ready → 0x10, 0x14, 0x18 drain in order with outputs stable while stalled.
- Simultaneous push/pop at count = 1: continuous stream of 8 sw at addresses 0x40–0x5C with out_ready = 1 → count stays 1, in_ready stays 1, all 8 emerge in order, one per cycle.
- Reset mid-operation: two entries buffered with out_ready = 0, assert rst for one cycle → out_valid = 0, in_ready = 1, ades = 0; previously buffered data never appears.

Source files
------------

// File: rtl/store_packer.sv
`default_nettype none
// ============================================================================
//  Module   : store_packer
//  Purpose  : Store-side formatter between the MEM stage and the data RAM.
//             Packs sb/sh/sw requests onto little-endian byte lanes, builds
//             byte enables, rejects misaligned/illegal stores with a one-cycle
//             ades pulse, and queues accepted stores in a small FIFO so RAM
//             back-pressure never drops a request.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             in_valid/in_ready        - request handshake (ready = not full)
//             in_addr, in_data,in_size - byte address, rt value, 00/01/10 size
//             out_valid/out_ready      - head-of-queue handshake toward RAM
//             out_addr,out_wdata,out_be- word address, replicated data, lanes
//             ades, bad_vaddr          - address-error pulse and its address
//  Revision : 1.0  initial release
// ============================================================================
module store_packer #(
    parameter int DEPTH = 2,   // store-buffer entries, power of two >= 2
    parameter int AW    = 32   // byte-address width, >= 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [31:0]   in_data,
    input  logic [1:0]    in_size,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [31:0]   out_wdata,
    output logic [3:0]    out_be,
    output logic          ades,
    output logic [AW-1:0] bad_vaddr
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    // ------------------------------------------------------------------
    // Lane packing and alignment check (combinational, before enqueue)
    // ------------------------------------------------------------------
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_err;

    always_comb begin
        w_wdata = in_data;
        w_be    = 4'b1111;
        w_err   = 1'b0;
        case (in_size)
            c_SZ_BYTE: begin
                w_wdata = {4{in_data[7:0]}};
                w_be    = 4'b0001 << in_addr[1:0];
            end
            c_SZ_HALF: begin
                w_wdata = {2{in_data[15:0]}};
                w_be    = in_addr[1] ? 4'b1100 : 4'b0011;
                w_err   = in_addr[0];
            end
            c_SZ_WORD: begin
                w_err   = (in_addr[1:0] != 2'b00);
            end
            default: begin
                // size 11 is illegal; the lane values are irrelevant since
                // the request is never enqueued
                w_err   = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes. A rejected request still consumes the input slot so the
    // pipeline can move on; it just never reaches the queue.
    // ------------------------------------------------------------------
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_accept;
    logic w_push;
    logic w_reject;
    logic w_pop;

    assign in_ready  = (r_count < c_FULL);
    assign out_valid = (r_count != '0);

    assign w_accept  = in_valid & in_ready;
    assign w_push    = w_accept & ~w_err;
    assign w_reject  = w_accept &  w_err;
    assign w_pop     = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Entry storage. Contents need no reset: the count alone decides
    // whether an entry is live, and outputs are masked while empty.
    // ------------------------------------------------------------------
    logic [AW-1:0] r_addr_q  [DEPTH];
    logic [31:0]   r_wdata_q [DEPTH];
    logic [3:0]    r_be_q    [DEPTH];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[r_wptr]  <= {in_addr[AW-1:2], 2'b00};
            r_wdata_q[r_wptr] <= w_wdata;
            r_be_q[r_wptr]    <= w_be;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy. DEPTH is a power of two, so the pointers
    // wrap naturally at their bit width.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Address-error reporting: pulse one cycle after the rejected
    // handshake; the faulting address is held until the next rejection.
    // ------------------------------------------------------------------
    logic          r_ades;
    logic [AW-1:0] r_bad_vaddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ades      <= 1'b0;
            r_bad_vaddr <= '0;
        end else begin
            r_ades <= w_reject;
            if (w_reject) begin
                r_bad_vaddr <= in_addr;
            end
        end
    end

    assign ades      = r_ades;
    assign bad_vaddr = r_bad_vaddr;

    // Head entry, forced to zero while the queue is empty
    assign out_addr  = out_valid ? r_addr_q[r_rptr]  : '0;
    assign out_wdata = out_valid ? r_wdata_q[r_rptr] : '0;
    assign out_be    = out_valid ? r_be_q[r_rptr]    : '0;

endmodule
`default_nettype wire

// File: tb/tb_store_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_packer
//  Purpose  : Self-checking bench for store_packer. A reference queue model
//             is updated from the driven stimulus and compared against the
//             DUT outputs every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_store_packer;

    localparam int DEPTH = 2;
    localparam int AW    = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [31:0]   in_data;
    logic [1:0]    in_size;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_wdata;
    logic [3:0]    out_be;
    logic          ades;
    logic [AW-1:0] bad_vaddr;

    store_packer #(.DEPTH(DEPTH), .AW(AW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_size   (in_size),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_wdata (out_wdata),
        .out_be    (out_be),
        .ades      (ades),
        .bad_vaddr (bad_vaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ent_t;

    ent_t        m_q[$];
    logic        m_ades = 1'b0;
    logic [31:0] m_bad  = '0;
    bit          chk_en = 0;
    bit          rnd_mode = 0;

    function automatic bit is_err(input logic [31:0] a, input logic [1:0] s);
        case (s)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return a[1:0] != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic ent_t pack(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        ent_t e;
        e.addr = a & 32'hFFFF_FFFC;
        case (s)
            2'd0: begin
                e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
                case (a[1:0])
                    2'd0: e.be = 4'b0001;
                    2'd1: e.be = 4'b0010;
                    2'd2: e.be = 4'b0100;
                    default: e.be = 4'b1000;
                endcase
            end
            2'd1: begin
                e.wdata = {d[15:0], d[15:0]};
                e.be    = a[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                e.wdata = d;
                e.be    = 4'b1111;
            end
        endcase
        return e;
    endfunction

    // Compare the state produced by the last rising edge, then advance the
    // model with what the next rising edge will see.
    initial begin
        bit hs, err, pop;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("in_ready",  in_ready,  m_q.size() < DEPTH);
                check("out_valid", out_valid, m_q.size() != 0);
                if (m_q.size() != 0) begin
                    check("out_addr",  out_addr,  m_q[0].addr);
                    check("out_wdata", out_wdata, m_q[0].wdata);
                    check("out_be",    out_be,    m_q[0].be);
                end else begin
                    check("idle_addr",  out_addr,  0);
                    check("idle_wdata", out_wdata, 0);
                    check("idle_be",    out_be,    0);
                end
                check("ades",      ades,      m_ades);
                check("bad_vaddr", bad_vaddr, m_bad);
            end
            if (rst) begin
                m_q.delete();
                m_ades = 1'b0;
                m_bad  = '0;
                chk_en = 1;
            end else begin
                hs     = in_valid && (m_q.size() < DEPTH);
                err    = hs && is_err(in_addr, in_size);
                m_ades = err;
                if (err) m_bad = in_addr;
                pop = (m_q.size() != 0) && out_ready;
                if (pop) void'(m_q.pop_front());
                if (hs && !err) m_q.push_back(pack(in_addr, in_data, in_size));
            end
        end
    end

    // Random back-pressure for the soak phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Hold a request until it handshakes; returns #1 after the accepting edge
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_size  = s;
        acc = 0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        in_size   = '0;
        out_ready = 1'b0;
        cycles(2);
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_ades",      ades,      0);
        check("rst_bad_vaddr", bad_vaddr, 0);

        // Byte lanes
        out_ready = 1'b1;
        send(32'h1003, 32'h0000_00A5, 2'd0);
        check("sb_valid", out_valid, 1);
        check("sb_addr",  out_addr,  32'h1000);
        check("sb_wdata", out_wdata, 32'hA5A5_A5A5);
        check("sb_be",    out_be,    4'b1000);
        cycles(1);
        check("sb_drained", out_valid, 0);

        // Half then word, in order
        out_ready = 1'b0;
        send(32'h2002, 32'h1234_BEEF, 2'd1);
        send(32'h2004, 32'hCAFE_F00D, 2'd2);
        check("sh_addr",  out_addr,  32'h2000);
        check("sh_wdata", out_wdata, 32'hBEEF_BEEF);
        check("sh_be",    out_be,    4'b1100);
        out_ready = 1'b1;
        cycles(1);
        check("sw_addr",  out_addr,  32'h2004);
        check("sw_wdata", out_wdata, 32'hCAFE_F00D);
        check("sw_be",    out_be,    4'b1111);
        cycles(2);

        // Misaligned, back to back
        send(32'h3001, 32'h1111_1111, 2'd1);
        check("mis1_ades", ades, 1);
        check("mis1_bad",  bad_vaddr, 32'h3001);
        send(32'h3006, 32'h2222_2222, 2'd2);
        check("mis2_ades", ades, 1);
        check("mis2_bad",  bad_vaddr, 32'h3006);
        check("mis2_valid", out_valid, 0);
        cycles(1);
        check("mis_ades_end", ades, 0);
        check("mis_bad_hold", bad_vaddr, 32'h3006);
        send(32'h3008, 32'h0, 2'd3);
        check("illegal_ades", ades, 1);

        // Back-pressure / full
        out_ready = 1'b0;
        send(32'h10, 32'hAAAA_0010, 2'd2);
        send(32'h14, 32'hAAAA_0014, 2'd2);
        check("full_ready", in_ready, 0);
        fork
            send(32'h18, 32'hAAAA_0018, 2'd2);
            begin
                cycles(3);
                check("held_ready", in_ready, 0);
                check("held_addr",  out_addr, 32'h10);
                out_ready = 1'b1;
            end
        join
        cycles(4);

        // Error presented while full is not taken until there is room
        out_ready = 1'b0;
        send(32'h20, 32'h1, 2'd2);
        send(32'h24, 32'h2, 2'd2);
        fork
            send(32'h27, 32'h3, 2'd2);
            begin
                cycles(3);
                check("full_err_noades", ades, 0);
                out_ready = 1'b1;
            end
        join
        check("full_err_ades", ades, 1);
        check("full_err_bad",  bad_vaddr, 32'h27);
        cycles(3);

        // Streaming with simultaneous push/pop
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(32'h40 + 32'(4 * i), 32'h5000_0000 + 32'(i), 2'd2);
            check("stream_ready", in_ready, 1);
        end
        cycles(3);

        // Reset mid-operation discards buffered entries
        out_ready = 1'b0;
        send(32'h80, 32'hDEAD_0080, 2'd2);
        send(32'h84, 32'hDEAD_0084, 2'd2);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("mrst_valid", out_valid, 0);
        check("mrst_ready", in_ready,  1);
        check("mrst_ades",  ades,      0);
        out_ready = 1'b1;
        cycles(4);

        // Random soak
        rnd_mode = 1;
        for (int i = 0; i < 80; i++) begin
            cycles($urandom_range(0, 2));
            send(32'h500 | ($urandom & 32'hFF), $urandom, 2'($urandom_range(0, 3)));
        end
        rnd_mode  = 0;
        out_ready = 1'b1;
        cycles(6);
        check("final_empty", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
